adc_ti_frame_gen: RTL and testbench
===================================

// Module: adc_ti_frame_gen
// PURPOSE
//  Parametrised, synthesizable time-interleaved ADC sample-frame source. Replaces fixed 96/48-lane behavioural stimulus.
//  Builds one NUM_CH-lane frame (lane 0 = oldest sample) LANES samples/cycle into a shadow buffer, then hands it to a
//  registered output slot via valid/ready. Pattern modes: sine, ramp, constant, PRBS9. Feeds the capture path in sim/FPGA.
// PARAMETERS
//  DATA_W   9   bits per sample, offset-binary
//  NUM_CH   96  lanes per frame; NUM_CH % (2*LANES) == 0
//  LANES    8   samples generated per clock
//  PHASE_W  16  phase accumulator width
//  LUT_AW   9   sine ROM address bits; LUT_AW <= PHASE_W
//  CNT_W    16  frame counter width
// PORTS
//  clk          in   1              single clock
//  reset        in   1              synchronous, active-high
//  en           in   1              start/continue frame generation
//  mode         in   2              0 sine, 1 ramp, 2 const, 3 PRBS9
//  half_mode    in   1              1: only lanes 0..NUM_CH/2-1 active (TI48-style)
//  phase_inc    in   PHASE_W        sine phase step per sample
//  const_val    in   DATA_W         sample value in const mode
//  frame_valid  out  1              output frame available
//  frame_ready  in   1              consumer accepts frame
//  frame_data   out  NUM_CH*DATA_W  lane k at [k*DATA_W +: DATA_W]
//  frame_cnt    out  CNT_W          accepted-frame count, wraps
//  busy         out  1              state != IDLE
// BEHAVIOUR
//  - Reset: frame_valid=0, frame_data=0, frame_cnt=0, busy=0; state IDLE; phase=0, ramp=0, lfsr=9'h1FF; shadow cleared.
//    Reset mid-BUILD/HOLD abandons the partial frame; the output slot is also emptied.
//  - FSM: IDLE --en--> BUILD (latch mode, half_mode, phase_inc, const_val, chunk=0).
//    BUILD: each cycle writes lanes chunk*LANES..+LANES-1. The last chunk (B-1) -> HOLD.
//    B = NUM_CH/LANES, or NUM_CH/(2*LANES) in half mode.
//    HOLD: transfers shadow->output when slot empty or (frame_valid & frame_ready) the same cycle.
//    On transfer: en ? BUILD (re-latch cfg) : IDLE. No transfer -> stay HOLD (backpressure; generators frozen).
//  - Latency: en sampled high in IDLE at edge t0 with slot empty -> frame_valid high after edge t0+B+1.
//    Sustained throughput is 1 frame per B+1 cycles.
//  - Config changes mid-frame are ignored until the next BUILD entry. Deasserting en mid-BUILD completes the frame.
//  - Output: frame_data/frame_valid stable while frame_valid & !frame_ready.
//    Accept (valid&ready) with no transfer -> frame_valid=0. frame_cnt += 1 per accept, mod 2^CNT_W.
//  - Inactive lanes in half mode are driven 0.
//  - Generators (state persists across frames, advance only per generated sample):
//    sine : lane j of chunk uses idx = (phase + j*phase_inc)[PHASE_W-1 -: LUT_AW]; phase += LANES*phase_inc, mod 2^PHASE_W.
//           ROM[i] = 2^(DATA_W-1) + round((2^(DATA_W-1)-1)*sin(2*pi*i/2^LUT_AW)).
//    ramp : sample = ramp mod 2^DATA_W; ramp += 1 per sample, wraps.
//    const: sample = latched const_val.
//    PRBS9: x^9+x^5+1 Fibonacci, one step per sample; sample = lfsr state before step, zero-extended/truncated to DATA_W.
//           LANES steps unrolled per cycle. A zero state never occurs.
//  - Mode switch keeps other generators' state unchanged.
// STRUCTURE
//  - Package adc_ti_pkg: mode_e enum (MODE_SINE, MODE_RAMP, MODE_CONST, MODE_PRBS), state_e (IDLE, BUILD, HOLD),
//    PRBS9 taps/seed constants.
//  - Sub-module adc_sine_rom: LANES read ports, ROM filled at elaboration by a constant function.
//    Combinational read, so a chunk's samples are written in the same cycle.
// TESTING (NUM_CH=96, LANES=8, DATA_W=9, PHASE_W=16, LUT_AW=9)
//  1 ramp, en=1, ready=1 -> first valid 13 edges after en.
//    Frame0 lanes = 0..95; frame1 lane0 = 96; frame5 lane32 = 0 (wrap). frame_cnt increments per frame.
//  2 sine, phase_inc=16'h1000 -> frame0 lane0=256, lane4=511, lane8=256, lane12=1. Consecutive frames continue the phase.
//  3 half_mode=1, ramp -> valid 7 edges after en. Lanes 0..47 = 0..47, lanes 48..95 = 0. Frame1 lane0 = 48.
//  4 ready=0 for 40 cycles -> frame_data stable, state HOLD, busy=1.
//    On ready=1, frame N+1 ramp continues with no sample gap or duplicate.
//  5 PRBS9 -> lane0=9'h1FF; sequence matches golden LFSR model. Period 511 samples across frames.
//  6 reset at chunk 5 of BUILD -> next cycle frame_valid=0, phase/ramp/lfsr reset.
//    Same cycle en high, mode change mid-frame -> takes effect only next frame.

Source files
------------

// File: rtl/adc_ti_pkg.sv
// Shared types and constants for the time-interleaved ADC frame source.
package adc_ti_pkg;

  typedef enum logic [1:0] {
    MODE_SINE  = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_PRBS  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int unsigned PRBS_W     = 9;
  localparam logic [8:0]  PRBS_SEED  = 9'h1FF;
  // x^9 + x^5 + 1 taps as state bit indices
  localparam int unsigned PRBS_TAP_A = 8;
  localparam int unsigned PRBS_TAP_B = 4;

  function automatic logic [PRBS_W-1:0] prbs9_step(input logic [PRBS_W-1:0] s);
    return {s[PRBS_W-2:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
  endfunction

endpackage

// File: rtl/adc_sine_rom.sv
// Multi-port combinational sine ROM, offset-binary, contents built at elaboration.
module adc_sine_rom #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned LUT_AW = 9,
  parameter int unsigned LANES  = 8
) (
  input  logic [LANES*LUT_AW-1:0] addr,
  output logic [LANES*DATA_W-1:0] data
);

  localparam int unsigned DEPTH = 1 << LUT_AW;
  localparam real         PI    = 3.14159265358979323846;

  function automatic logic [DEPTH*DATA_W-1:0] gen_rom();
    logic [DEPTH*DATA_W-1:0] r;
    real                     amp;
    real                     v;
    int                      s;
    r   = '0;
    amp = real'((1 << (DATA_W - 1)) - 1);
    for (int i = 0; i < int'(DEPTH); i++) begin
      v = amp * $sin(2.0 * PI * real'(i) / real'(DEPTH));
      // Round half away from zero so the table is symmetric about midscale
      s = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
      r[i*DATA_W +: DATA_W] = DATA_W'((1 << (DATA_W - 1)) + s);
    end
    return r;
  endfunction

  localparam logic [DEPTH*DATA_W-1:0] ROM = gen_rom();

  always_comb begin
    data = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      data[j*DATA_W +: DATA_W] = ROM[int'(addr[j*LUT_AW +: LUT_AW])*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/adc_ti_frame_gen.sv
// Time-interleaved ADC frame source: builds a NUM_CH-lane frame LANES samples per cycle
// into a shadow buffer and hands it to a registered valid/ready output slot.
module adc_ti_frame_gen
  import adc_ti_pkg::*;
#(
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned NUM_CH  = 96,
  parameter int unsigned LANES   = 8,
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned LUT_AW  = 9,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     half_mode,
  input  logic [PHASE_W-1:0]       phase_inc,
  input  logic [DATA_W-1:0]        const_val,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [NUM_CH*DATA_W-1:0] frame_data,
  output logic [CNT_W-1:0]         frame_cnt,
  output logic                     busy
);

  localparam int unsigned NCHUNK     = NUM_CH / LANES;
  localparam int unsigned HCHUNK     = NUM_CH / (2 * LANES);
  localparam int unsigned CHUNK_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CHUNK_BITS = LANES * DATA_W;
  localparam int unsigned HALF_BITS  = NUM_CH * DATA_W / 2;

  if (NUM_CH % (2 * LANES) != 0) begin : g_bad_num_ch
    $error("NUM_CH must be a multiple of 2*LANES");
  end
  if (LUT_AW > PHASE_W) begin : g_bad_lut_aw
    $error("LUT_AW must not exceed PHASE_W");
  end

  state_e                   state_q;
  logic [CHUNK_W-1:0]       chunk_q;
  logic [CHUNK_W-1:0]       last_chunk;
  mode_e                    cfg_mode_q;
  logic                     cfg_half_q;
  logic [PHASE_W-1:0]       cfg_inc_q;
  logic [DATA_W-1:0]        cfg_const_q;
  logic [PHASE_W-1:0]       phase_q;
  logic [PHASE_W-1:0]       lane_phase;
  logic [PHASE_W-1:0]       phase_next;
  logic [DATA_W-1:0]        ramp_q;
  logic [DATA_W-1:0]        ramp_lane;
  logic [PRBS_W-1:0]        lfsr_q;
  logic [PRBS_W-1:0]        lfsr_walk;
  logic [PRBS_W-1:0]        lfsr_next;
  logic [DATA_W+PRBS_W-1:0] prbs_ext;
  logic [CHUNK_BITS-1:0]    shadow_q [NCHUNK];
  logic [LANES*LUT_AW-1:0]  rom_addr;
  logic [CHUNK_BITS-1:0]    rom_data;
  logic [CHUNK_BITS-1:0]    chunk_data;
  logic [NUM_CH*DATA_W-1:0] frame_next;
  logic                     accept;
  logic                     xfer;

  assign busy       = (state_q != IDLE);
  assign accept     = frame_valid & frame_ready;
  // Slot is free when empty or being drained on this same edge
  assign xfer       = (state_q == HOLD) && (!frame_valid || frame_ready);
  assign last_chunk = cfg_half_q ? CHUNK_W'(HCHUNK - 1) : CHUNK_W'(NCHUNK - 1);

  always_comb begin
    rom_addr   = '0;
    lane_phase = phase_q;
    for (int j = 0; j < int'(LANES); j++) begin
      rom_addr[j*LUT_AW +: LUT_AW] = lane_phase[PHASE_W-1 -: LUT_AW];
      lane_phase = lane_phase + cfg_inc_q;
    end
    phase_next = lane_phase;
  end

  adc_sine_rom #(
    .DATA_W (DATA_W),
    .LUT_AW (LUT_AW),
    .LANES  (LANES)
  ) u_sine_rom (
    .addr (rom_addr),
    .data (rom_data)
  );

  always_comb begin
    chunk_data = '0;
    ramp_lane  = '0;
    prbs_ext   = '0;
    lfsr_walk  = lfsr_q;
    for (int j = 0; j < int'(LANES); j++) begin
      ramp_lane = ramp_q + DATA_W'(j);
      prbs_ext  = {{DATA_W{1'b0}}, lfsr_walk};
      case (cfg_mode_q)
        MODE_SINE:  chunk_data[j*DATA_W +: DATA_W] = rom_data[j*DATA_W +: DATA_W];
        MODE_RAMP:  chunk_data[j*DATA_W +: DATA_W] = ramp_lane;
        MODE_CONST: chunk_data[j*DATA_W +: DATA_W] = cfg_const_q;
        default:    chunk_data[j*DATA_W +: DATA_W] = prbs_ext[DATA_W-1:0];
      endcase
      lfsr_walk = prbs9_step(lfsr_walk);
    end
    lfsr_next = lfsr_walk;
  end

  always_comb begin
    frame_next = '0;
    for (int c = 0; c < int'(NCHUNK); c++) begin
      frame_next[c*CHUNK_BITS +: CHUNK_BITS] = shadow_q[c];
    end
    // Upper lanes may still hold a stale full-width frame
    if (cfg_half_q) begin
      frame_next[NUM_CH*DATA_W-1 -: HALF_BITS] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      chunk_q     <= '0;
      cfg_mode_q  <= MODE_SINE;
      cfg_half_q  <= 1'b0;
      cfg_inc_q   <= '0;
      cfg_const_q <= '0;
      phase_q     <= '0;
      ramp_q      <= '0;
      lfsr_q      <= PRBS_SEED;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_cnt   <= '0;
      for (int c = 0; c < int'(NCHUNK); c++) begin
        shadow_q[c] <= '0;
      end
    end else begin
      if (accept) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (xfer) begin
        frame_valid <= 1'b1;
        frame_data  <= frame_next;
      end else if (accept) begin
        frame_valid <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (en) begin
            cfg_mode_q  <= mode_e'(mode);
            cfg_half_q  <= half_mode;
            cfg_inc_q   <= phase_inc;
            cfg_const_q <= const_val;
            chunk_q     <= '0;
            state_q     <= BUILD;
          end
        end
        BUILD: begin
          shadow_q[chunk_q] <= chunk_data;
          case (cfg_mode_q)
            MODE_SINE: phase_q <= phase_next;
            MODE_RAMP: ramp_q  <= ramp_q + DATA_W'(LANES);
            MODE_PRBS: lfsr_q  <= lfsr_next;
            default:   ;
          endcase
          if (chunk_q == last_chunk) begin
            state_q <= HOLD;
          end else begin
            chunk_q <= chunk_q + CHUNK_W'(1);
          end
        end
        HOLD: begin
          if (xfer) begin
            if (en) begin
              cfg_mode_q  <= mode_e'(mode);
              cfg_half_q  <= half_mode;
              cfg_inc_q   <= phase_inc;
              cfg_const_q <= const_val;
              chunk_q     <= '0;
              state_q     <= BUILD;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_ti_frame_gen.sv
// Directed self-checking bench for adc_ti_frame_gen at the 96-lane, 8-lane/cycle configuration.
module tb_adc_ti_frame_gen;
  import adc_ti_pkg::*;

  localparam int DATA_W  = 9;
  localparam int NUM_CH  = 96;
  localparam int LANES   = 8;
  localparam int PHASE_W = 16;
  localparam int LUT_AW  = 9;
  localparam int CNT_W   = 16;
  localparam int FW      = NUM_CH * DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [1:0]        mode;
  logic              half_mode;
  logic [PHASE_W-1:0] phase_inc;
  logic [DATA_W-1:0] const_val;
  logic              frame_valid;
  logic              frame_ready;
  logic [FW-1:0]     frame_data;
  logic [CNT_W-1:0]  frame_cnt;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_ti_frame_gen #(
    .DATA_W  (DATA_W),
    .NUM_CH  (NUM_CH),
    .LANES   (LANES),
    .PHASE_W (PHASE_W),
    .LUT_AW  (LUT_AW),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .mode        (mode),
    .half_mode   (half_mode),
    .phase_inc   (phase_inc),
    .const_val   (const_val),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  function automatic logic [DATA_W-1:0] lane(input logic [FW-1:0] f, input int k);
    return f[k*DATA_W +: DATA_W];
  endfunction

  task automatic apply_reset;
    @(negedge clk);
    reset       = 1'b1;
    en          = 1'b0;
    mode        = 2'd0;
    half_mode   = 1'b0;
    phase_inc   = '0;
    const_val   = '0;
    frame_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Edges until frame_valid is seen (sampled at negedge); -1 on timeout.
  task automatic wait_valid(output int edges);
    edges = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (frame_valid) begin
        edges = i;
        return;
      end
    end
  endtask

  task automatic get_frame(output logic [FW-1:0] f, input string name);
    int e;
    wait_valid(e);
    f = frame_data;
    checks++;
    if (e < 0) begin
      errors++;
      $display("FAIL %s: frame_valid timeout, got edges=%0d, want >0", name, e);
    end
  endtask

  task automatic test_reset;
    apply_reset;
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", frame_valid);
    end
    checks++;
    if (frame_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (frame_data !== '0) begin
      errors++; $display("FAIL reset_data: got %h want 0", frame_data);
    end
  endtask

  task automatic test_ramp;
    logic [FW-1:0] f;
    int e, bad, first;
    apply_reset;
    mode = 2'd1;
    en   = 1'b1;
    @(posedge clk);
    wait_valid(e);
    checks++;
    if (e !== 13) begin
      errors++; $display("FAIL ramp_latency: got %0d edges want 13", e);
    end
    f = frame_data;
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++; $display("FAIL ramp_cnt0: got %0d want 0", frame_cnt);
    end
    bad = 0; first = -1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (lane(f, k) !== DATA_W'(k)) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ramp_frame0: lane %0d got %0d want %0d (%0d bad)", first,
               lane(f, first), first, bad);
    end
    get_frame(f, "ramp_f1");
    checks++;
    if (lane(f, 0) !== 9'd96) begin
      errors++; $display("FAIL ramp_f1_lane0: got %0d want 96", lane(f, 0));
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++; $display("FAIL ramp_cnt1: got %0d want 1", frame_cnt);
    end
    for (int n = 2; n <= 5; n++) get_frame(f, "ramp_fn");
    checks++;
    if (lane(f, 31) !== 9'd511) begin
      errors++; $display("FAIL ramp_f5_lane31: got %0d want 511", lane(f, 31));
    end
    checks++;
    if (lane(f, 32) !== 9'd0) begin
      errors++; $display("FAIL ramp_f5_wrap: got %0d want 0", lane(f, 32));
    end
    checks++;
    if (frame_cnt !== 16'd5) begin
      errors++; $display("FAIL ramp_cnt5: got %0d want 5", frame_cnt);
    end
  endtask

  task automatic test_sine;
    logic [FW-1:0] f;
    logic [DATA_W-1:0] want [4];
    want[0] = 9'd256; want[1] = 9'd511; want[2] = 9'd256; want[3] = 9'd1;
    apply_reset;
    mode      = 2'd0;
    phase_inc = 16'h1000;
    en        = 1'b1;
    get_frame(f, "sine_f0");
    for (int q = 0; q < 4; q++) begin
      checks++;
      if (lane(f, 4 * q) !== want[q]) begin
        errors++;
        $display("FAIL sine_f0_lane%0d: got %0d want %0d", 4 * q, lane(f, 4 * q), want[q]);
      end
    end
    get_frame(f, "sine_f1");
    checks++;
    if (lane(f, 4) !== 9'd511 || lane(f, 12) !== 9'd1) begin
      errors++;
      $display("FAIL sine_f1_cont: got %0d,%0d want 511,1", lane(f, 4), lane(f, 12));
    end
    // One ROM entry per sample: exposes phase carry across frames
    apply_reset;
    mode      = 2'd0;
    phase_inc = 16'h0080;
    en        = 1'b1;
    get_frame(f, "sine_fine_f0");
    checks++;
    if (lane(f, 0) !== 9'd256 || lane(f, 64) !== 9'd436) begin
      errors++;
      $display("FAIL sine_fine_f0: got %0d,%0d want 256,436", lane(f, 0), lane(f, 64));
    end
    get_frame(f, "sine_fine_f1");
    checks++;
    if (lane(f, 0) !== 9'd492) begin
      errors++; $display("FAIL sine_fine_f1_lane0: got %0d want 492", lane(f, 0));
    end
  endtask

  task automatic test_half;
    logic [FW-1:0] f;
    int e, bad;
    apply_reset;
    mode      = 2'd1;
    half_mode = 1'b1;
    en        = 1'b1;
    @(posedge clk);
    wait_valid(e);
    checks++;
    if (e !== 7) begin
      errors++; $display("FAIL half_latency: got %0d edges want 7", e);
    end
    f = frame_data;
    bad = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (lane(f, k) !== ((k < 48) ? DATA_W'(k) : DATA_W'(0))) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL half_frame0: got %0d bad lanes want 0", bad);
    end
    get_frame(f, "half_f1");
    checks++;
    if (lane(f, 0) !== 9'd48) begin
      errors++; $display("FAIL half_f1_lane0: got %0d want 48", lane(f, 0));
    end
    // Full frame with en dropped mid-build, then a half frame over the stale shadow
    apply_reset;
    mode = 2'd1;
    en   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    get_frame(f, "half_full_f0");
    checks++;
    if (lane(f, 95) !== 9'd95) begin
      errors++; $display("FAIL en_drop_complete: got %0d want 95", lane(f, 95));
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL en_drop_idle: busy got %b want 0", busy);
    end
    half_mode = 1'b1;
    en        = 1'b1;
    get_frame(f, "half_mask_f");
    checks++;
    if (lane(f, 0) !== 9'd96 || lane(f, 47) !== 9'd143) begin
      errors++;
      $display("FAIL half_mask_low: got %0d,%0d want 96,143", lane(f, 0), lane(f, 47));
    end
    checks++;
    if (lane(f, 48) !== 9'd0 || lane(f, 95) !== 9'd0) begin
      errors++;
      $display("FAIL half_mask_high: got %0d,%0d want 0,0", lane(f, 48), lane(f, 95));
    end
  endtask

  task automatic test_backpressure;
    logic [FW-1:0] f, snap;
    int e;
    logic stable;
    apply_reset;
    mode        = 2'd1;
    frame_ready = 1'b0;
    en          = 1'b1;
    @(posedge clk);
    wait_valid(e);
    checks++;
    if (e !== 13) begin
      errors++; $display("FAIL bp_latency: got %0d edges want 13", e);
    end
    snap   = frame_data;
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (frame_data !== snap || frame_valid !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++; $display("FAIL bp_stable: got %b want 1", stable);
    end
    checks++;
    if (lane(snap, 95) !== 9'd95) begin
      errors++; $display("FAIL bp_f0_lane95: got %0d want 95", lane(snap, 95));
    end
    checks++;
    if (dut.state_q !== HOLD || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: got state=%0d busy=%b want state=%0d busy=1", dut.state_q, busy,
               HOLD);
    end
    frame_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (frame_valid !== 1'b1 || lane(frame_data, 0) !== 9'd96 || lane(frame_data, 95) !== 9'd191)
    begin
      errors++;
      $display("FAIL bp_f1_b2b: got valid=%b lane0=%0d lane95=%0d want 1,96,191", frame_valid,
               lane(frame_data, 0), lane(frame_data, 95));
    end
    get_frame(f, "bp_f2");
    checks++;
    if (lane(f, 0) !== 9'd192) begin
      errors++; $display("FAIL bp_f2_lane0: got %0d want 192", lane(f, 0));
    end
    checks++;
    if (frame_cnt !== 16'd2) begin
      errors++; $display("FAIL bp_cnt: got %0d want 2", frame_cnt);
    end
  endtask

  task automatic test_prbs;
    logic [FW-1:0] f;
    logic [8:0] m;
    logic [DATA_W-1:0] f0_lane0, f5_lane31;
    int bad, first_fr, first_k;
    apply_reset;
    mode = 2'd3;
    en   = 1'b1;
    m = 9'h1FF;
    bad = 0; first_fr = -1; first_k = -1;
    f0_lane0 = '0; f5_lane31 = '0;
    for (int fr = 0; fr < 6; fr++) begin
      get_frame(f, "prbs_f");
      if (fr == 0) f0_lane0 = lane(f, 0);
      if (fr == 5) f5_lane31 = lane(f, 31);
      for (int k = 0; k < NUM_CH; k++) begin
        if (lane(f, k) !== m) begin
          bad++;
          if (first_fr < 0) begin first_fr = fr; first_k = k; end
        end
        m = {m[7:0], m[8] ^ m[4]};
      end
    end
    checks++;
    if (f0_lane0 !== 9'h1FF) begin
      errors++; $display("FAIL prbs_seed: got %h want 1ff", f0_lane0);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL prbs_seq: got %0d bad samples (first frame %0d lane %0d) want 0", bad,
               first_fr, first_k);
    end
    checks++;
    if (f5_lane31 !== 9'h1FF) begin
      errors++; $display("FAIL prbs_period: got %h want 1ff", f5_lane31);
    end
  endtask

  task automatic test_reset_mid_build;
    logic [FW-1:0] f;
    int e;
    apply_reset;
    mode        = 2'd1;
    frame_ready = 1'b0;
    en          = 1'b1;
    @(posedge clk);
    wait_valid(e);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (frame_valid !== 1'b0 || busy !== 1'b0 || frame_data !== '0) begin
      errors++;
      $display("FAIL midreset_out: got valid=%b busy=%b data_nz=%b want 0,0,0", frame_valid,
               busy, |frame_data);
    end
    checks++;
    if (dut.ramp_q !== '0 || dut.lfsr_q !== 9'h1FF || dut.phase_q !== '0) begin
      errors++;
      $display("FAIL midreset_gen: got ramp=%0d lfsr=%h phase=%h want 0,1ff,0", dut.ramp_q,
               dut.lfsr_q, dut.phase_q);
    end
    reset       = 1'b0;
    frame_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    mode      = 2'd2;
    const_val = 9'h055;
    get_frame(f, "cfg_f0");
    checks++;
    if (lane(f, 0) !== 9'd0 || lane(f, 95) !== 9'd95) begin
      errors++;
      $display("FAIL cfg_midframe: got %0d,%0d want 0,95", lane(f, 0), lane(f, 95));
    end
    get_frame(f, "cfg_f1");
    checks++;
    if (lane(f, 0) !== 9'h055 || lane(f, 95) !== 9'h055) begin
      errors++;
      $display("FAIL const_f1: got %h,%h want 55,55", lane(f, 0), lane(f, 95));
    end
    mode = 2'd1;
    get_frame(f, "cfg_f2");
    checks++;
    if (lane(f, 0) !== 9'h055) begin
      errors++; $display("FAIL const_f2_latched: got %h want 55", lane(f, 0));
    end
    get_frame(f, "cfg_f3");
    checks++;
    if (lane(f, 0) !== 9'd96) begin
      errors++; $display("FAIL ramp_resume: got %0d want 96", lane(f, 0));
    end
  endtask

  initial begin
    reset       = 1'b1;
    en          = 1'b0;
    mode        = 2'd0;
    half_mode   = 1'b0;
    phase_inc   = '0;
    const_val   = '0;
    frame_ready = 1'b1;
    test_reset;
    test_ramp;
    test_sine;
    test_half;
    test_backpressure;
    test_prbs;
    test_reset_mid_build;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
